// File: rtl/barrelshifter_pipe.sv
// Two-stage pipelined ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
// Stage 1 normalises the op/amount, stage 2 shifts; both advance together under valid/ready.
module barrelshifter_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] shift_data,
    input  logic [NUM_W-1:0]  shift_num,
    input  logic              carry_flag,
    input  logic [2:0]        shift_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] shift_out,
    output logic              shift_carry_out
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [NUM_W-1:0] W_AMT = NUM_W'(DATA_W);

    typedef enum logic [2:0] {
        OP_PASS,
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX
    } op_e;

    logic              adv;
    op_e               nxt_op;
    logic [NUM_W-1:0]  nxt_amt;

    logic              s1_valid;
    op_e               s1_op;
    logic [NUM_W-1:0]  s1_amt;
    logic [DATA_W-1:0] s1_data;
    logic              s1_carry;

    logic [DATA_W:0]        lsl_ext;
    logic [DATA_W:0]        lsr_ext;
    logic signed [DATA_W:0] asr_ext;
    logic [DATA_W-1:0]      rot;
    logic [DATA_W-1:0]      res_data;
    logic                   res_carry;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Fold the immediate #0 special encodings into plain ops so stage 2 only sees amounts.
    always_comb begin
        nxt_op  = OP_PASS;
        nxt_amt = shift_num;
        if (shift_num == '0 && (shift_op[0] || shift_op[2:1] == 2'b00)) begin
            nxt_op = OP_PASS;
        end else begin
            case (shift_op[2:1])
                2'b00: nxt_op = OP_LSL;
                2'b01: begin
                    nxt_op = OP_LSR;
                    if (shift_num == '0) nxt_amt = W_AMT;
                end
                2'b10: begin
                    nxt_op = OP_ASR;
                    if (shift_num == '0) nxt_amt = W_AMT;
                end
                default: begin
                    if (shift_num == '0) begin
                        nxt_op = OP_RRX;
                    end else begin
                        nxt_op  = OP_ROR;
                        nxt_amt = NUM_W'(shift_num[SH_W-1:0]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_PASS;
            s1_amt   <= '0;
            s1_data  <= '0;
            s1_carry <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= nxt_op;
                s1_amt   <= nxt_amt;
                s1_data  <= shift_data;
                s1_carry <= carry_flag;
            end
        end
    end

    // The extra guard bit on each shift captures the last bit shifted out as the carry.
    always_comb begin
        lsl_ext   = {1'b0, s1_data} << s1_amt;
        lsr_ext   = {s1_data, 1'b0} >> s1_amt;
        asr_ext   = $signed({s1_data, 1'b0}) >>> s1_amt;
        rot       = DATA_W'({s1_data, s1_data} >> s1_amt);
        res_data  = s1_data;
        res_carry = s1_carry;
        case (s1_op)
            OP_LSL: begin
                res_data  = lsl_ext[DATA_W-1:0];
                res_carry = lsl_ext[DATA_W];
            end
            OP_LSR: begin
                res_data  = lsr_ext[DATA_W:1];
                res_carry = lsr_ext[0];
            end
            OP_ASR: begin
                if (s1_amt >= W_AMT) begin
                    res_data  = {DATA_W{s1_data[DATA_W-1]}};
                    res_carry = s1_data[DATA_W-1];
                end else begin
                    res_data  = asr_ext[DATA_W:1];
                    res_carry = asr_ext[0];
                end
            end
            OP_ROR: begin
                res_data  = rot;
                res_carry = rot[DATA_W-1];
            end
            OP_RRX: begin
                res_data  = {s1_carry, s1_data[DATA_W-1:1]};
                res_carry = s1_data[0];
            end
            default: begin
                res_data  = s1_data;
                res_carry = s1_carry;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            shift_out       <= '0;
            shift_carry_out <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                shift_out       <= res_data;
                shift_carry_out <= res_carry;
            end
        end
    end

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Self-checking bench for barrelshifter_pipe: directed cases from the shifter's rules plus
// randomized traffic scored against a behavioural model and an in-order expectation queue.
module tb_barrelshifter_pipe;

    localparam logic [2:0] LSL_I = 3'b000, LSL_R = 3'b001, LSR_I = 3'b010, LSR_R = 3'b011;
    localparam logic [2:0] ASR_I = 3'b100, ASR_R = 3'b101, ROR_I = 3'b110, ROR_R = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] shift_data = '0;
    logic [7:0]  shift_num = '0;
    logic        carry_flag = 1'b0;
    logic [2:0]  shift_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] shift_out;
    logic        shift_carry_out;

    barrelshifter_pipe #(.DATA_W(32), .NUM_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .shift_data(shift_data), .shift_num(shift_num), .carry_flag(carry_flag),
        .shift_op(shift_op), .out_valid(out_valid), .out_ready(out_ready),
        .shift_out(shift_out), .shift_carry_out(shift_carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] exp;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t         sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cycle = 0;
    bit          lat_check = 0;
    bit          prev_stall = 0;
    logic [32:0] prev_out = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Reference written directly from the shift rules with 32-bit arithmetic; result is {carry, out}.
    function automatic logic [32:0] refShift(input logic [31:0] d, input logic [7:0] num,
                                             input logic cf, input logic [2:0] op);
        int          n;
        int          r;
        logic [31:0] o;
        logic        c;
        n = int'(num);
        if (n == 0 && (op[0] || op[2:1] == 2'b00)) return {cf, d};
        case (op[2:1])
            2'b00: begin
                if (n > 32) return 33'd0;
                o = (n == 32) ? 32'd0 : d << n;
                c = d[32 - n];
            end
            2'b01: begin
                if (n == 0) n = 32;
                if (n > 32) return 33'd0;
                o = (n == 32) ? 32'd0 : d >> n;
                c = d[n - 1];
            end
            2'b10: begin
                if (n == 0) n = 32;
                if (n >= 32) begin
                    o = d[31] ? 32'hFFFF_FFFF : 32'd0;
                    c = d[31];
                end else begin
                    o = $signed(d) >>> n;
                    c = d[n - 1];
                end
            end
            default: begin
                if (n == 0) begin
                    o = {cf, d[31:1]};
                    c = d[0];
                end else begin
                    r = n % 32;
                    if (r == 0) begin
                        o = d;
                        c = d[31];
                    end else begin
                        o = (d >> r) | (d << (32 - r));
                        c = d[r - 1];
                    end
                end
            end
        endcase
        return {c, o};
    endfunction

    // One clock cycle: drive inputs, score outputs at the falling edge, then step past the rising edge.
    task automatic applyStimulus(input logic rst_v, input logic vld, input logic [31:0] d,
                                 input logic [7:0] num, input logic cf, input logic [2:0] op,
                                 input logic rdy, input bit use_exp, input logic [32:0] exp_v,
                                 output bit accepted);
        sb_t e;
        rst        = rst_v;
        in_valid   = vld;
        shift_data = d;
        shift_num  = num;
        carry_flag = cf;
        shift_op   = op;
        out_ready  = rdy;
        accepted   = 0;
        @(negedge clk);
        if (rst_v) begin
            sb_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'({shift_carry_out, shift_out}), 64'(prev_out));
            end
            if (out_valid && !out_ready) checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_result", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result", 64'({shift_carry_out, shift_out}), 64'(e.exp));
                    if (e.lat) checkOutput("latency", 64'(cycle - e.acc), 64'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {shift_carry_out, shift_out};
            if (vld && in_ready) begin
                accepted = 1;
                e.exp = use_exp ? exp_v : refShift(d, num, cf, op);
                e.acc = cycle;
                e.lat = lat_check;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n, input logic rdy);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, rdy, 0, '0, acc);
    endtask

    task automatic sendDirected(input logic [31:0] d, input logic [7:0] num, input logic cf,
                                input logic [2:0] op, input logic [32:0] exp_v);
        bit acc;
        applyStimulus(0, 1, d, num, cf, op, 1, 1, exp_v, acc);
        checkOutput("directed_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) idle(1, 1);
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acc;
        int          accepts;
        int          idx;
        logic [31:0] bp_data[4];
        bit          pend;
        logic [31:0] rd;
        logic [7:0]  rn;
        logic        rc;
        logic [2:0]  ro;

        // Reset and idle state
        applyStimulus(1, 0, '0, '0, 0, '0, 0, 0, '0, acc);
        applyStimulus(1, 0, '0, '0, 0, '0, 0, 0, '0, acc);
        rst = 0;
        in_valid = 0;
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_shift_out", 64'(shift_out), 64'd0);
        checkOutput("reset_carry", 64'(shift_carry_out), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        cycle++;

        // Back-to-back LSL with exact latency
        lat_check = 1;
        sendDirected(32'h8000_0001, 8'd1, 0, LSL_I, {1'b1, 32'h0000_0002});
        sendDirected(32'h8000_0001, 8'd33, 0, LSL_I, {1'b0, 32'h0000_0000});
        sendDirected(32'h8000_0001, 8'd0, 1, LSL_R, {1'b1, 32'h8000_0001});
        // Immediate #0 encodings
        sendDirected(32'h8000_0001, 8'd0, 1, LSR_I, {1'b1, 32'h0000_0000});
        sendDirected(32'h8000_0001, 8'd0, 1, ASR_I, {1'b1, 32'hFFFF_FFFF});
        sendDirected(32'h8000_0001, 8'd0, 1, ROR_I, {1'b1, 32'hC000_0000});
        // Large rotate / shift amounts
        sendDirected(32'h0000_F00F, 8'd36, 0, ROR_R, {1'b1, 32'hF000_0F00});
        sendDirected(32'h0000_F00F, 8'd64, 0, ROR_R, {1'b0, 32'h0000_F00F});
        sendDirected(32'h7FFF_FFFF, 8'd200, 0, ASR_R, {1'b0, 32'h0000_0000});
        sendDirected(32'h8000_0000, 8'd32, 0, LSR_R, {1'b1, 32'h0000_0000});
        sendDirected(32'h0000_0001, 8'd32, 0, LSL_R, {1'b1, 32'h0000_0000});
        drain();
        lat_check = 0;

        // Backpressure: consumer stalls for 5 cycles while 4 requests are offered
        bp_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        accepts = 0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, idx < 4, bp_data[idx % 4], 8'd4, 0, ROR_R, 0, 0, '0, acc);
            if (acc) begin
                accepts++;
                idx++;
            end
        end
        checkOutput("bp_accepts_during_stall", 64'(accepts), 64'd2);
        for (int i = 0; i < 20 && idx < 4; i++) begin
            applyStimulus(0, 1, bp_data[idx], 8'd4, 0, ROR_R, 1, 0, '0, acc);
            if (acc) idx++;
        end
        checkOutput("bp_all_accepted", 64'(idx), 64'd4);
        drain();

        // Reset with two requests in flight: neither may emerge
        applyStimulus(0, 1, 32'hAAAA_5555, 8'd3, 0, LSL_R, 0, 0, '0, acc);
        applyStimulus(0, 1, 32'h5555_AAAA, 8'd5, 0, LSR_R, 0, 0, '0, acc);
        applyStimulus(1, 0, '0, '0, 0, '0, 0, 0, '0, acc);
        checkOutput("rst_flush_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_flush_in_ready", 64'(in_ready), 64'd1);
        idle(5, 1);

        // Randomized traffic with random backpressure
        pend = 0;
        rd = '0; rn = '0; rc = 0; ro = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 4) != 0) begin
                rd = $urandom;
                case ($urandom_range(0, 3))
                    0: rn = 8'd0;
                    1: rn = 8'($urandom_range(1, 33));
                    2: rn = 8'($urandom_range(30, 70));
                    default: rn = 8'($urandom_range(0, 255));
                endcase
                rc = 1'($urandom);
                ro = 3'($urandom);
                pend = 1;
            end
            applyStimulus(0, pend, rd, rn, rc, ro, $urandom_range(0, 3) != 0, 0, '0, acc);
            if (acc) pend = 0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
